// File: rtl/alu_pkg.sv
// Shared ALU result definitions: datapath widths and the result entry carried
// from the ALU into the result stage.
package alu_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int FLAG_WIDTH = 5;
  localparam int RD_WIDTH   = 5;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [FLAG_WIDTH-1:0] flag;
    logic [RD_WIDTH-1:0]   rd;
    logic                  we;
  } alu_result_t;

endpackage

// File: rtl/alu_result_stage.sv
// Two-entry in-order result buffer between the ALU and writeback, with a
// forwarding tap on the youngest held result.
module alu_result_stage #(
  parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH,
  parameter int FLAG_WIDTH = alu_pkg::FLAG_WIDTH,
  parameter int RD_WIDTH   = alu_pkg::RD_WIDTH
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  in_valid,
  output logic                  out_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [FLAG_WIDTH-1:0] in_ALU_flag,
  input  logic [RD_WIDTH-1:0]   in_rd,
  input  logic                  in_we,
  input  logic                  in_flush,
  output logic                  out_valid,
  input  logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [FLAG_WIDTH-1:0] out_ALU_flag,
  output logic [RD_WIDTH-1:0]   out_rd,
  output logic                  out_we,
  output logic                  out_fwd_valid,
  output logic [RD_WIDTH-1:0]   out_fwd_rd,
  output logic [DATA_WIDTH-1:0] out_fwd_data,
  output logic [1:0]            out_count
);

  typedef alu_pkg::alu_result_t entry_t;

  // Entries use the shared struct, so the widths must agree with the package.
  if (DATA_WIDTH != alu_pkg::DATA_WIDTH || FLAG_WIDTH != alu_pkg::FLAG_WIDTH ||
      RD_WIDTH != alu_pkg::RD_WIDTH) begin : g_width_check
    $error("alu_result_stage widths must match alu_pkg");
  end

  entry_t     entries_q [2];
  entry_t     entries_d [2];
  logic       head_q, head_d;
  logic [1:0] count_q, count_d;

  logic       do_accept, do_drain;
  logic       wr_idx, young_idx;
  entry_t     in_e, head_e, young_e;

  always_comb begin
    out_ready = (count_q < 2'd2);
    out_valid = (count_q != 2'd0);
    do_accept = in_valid & out_ready;
    do_drain  = out_valid & in_ready;

    // Tail slot sits one past the head when an entry is already held.
    wr_idx    = head_q ^ count_q[0];
    young_idx = head_q ^ count_q[1];

    in_e.data = in_data;
    in_e.flag = in_ALU_flag;
    in_e.rd   = in_rd;
    in_e.we   = in_we & (in_rd != '0);

    entries_d = entries_q;
    head_d    = head_q;
    count_d   = count_q;

    if (in_flush) begin
      count_d = 2'd0;
      head_d  = 1'b0;
    end else begin
      if (do_accept) entries_d[wr_idx] = in_e;
      if (do_drain)  head_d = ~head_q;
      count_d = count_q + {1'b0, do_accept} - {1'b0, do_drain};
    end
  end

  always_comb begin
    head_e        = entries_q[head_q];
    young_e       = entries_q[young_idx];
    out_data      = out_valid ? head_e.data : '0;
    out_ALU_flag  = out_valid ? head_e.flag : '0;
    out_rd        = out_valid ? head_e.rd   : '0;
    out_we        = out_valid & head_e.we;
    out_fwd_valid = out_valid & young_e.we;
    out_fwd_rd    = young_e.rd;
    out_fwd_data  = young_e.data;
    out_count     = count_q;
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      entries_q[0] <= '0;
      entries_q[1] <= '0;
      head_q       <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios followed by
// randomized traffic compared against a queue-based reference model.
module tb_alu_result_stage;

  localparam int DW = 64;
  localparam int FW = 5;
  localparam int RW = 5;

  logic          in_clk = 1'b0;
  logic          in_rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready;
  logic [DW-1:0] in_data = '0;
  logic [FW-1:0] in_ALU_flag = '0;
  logic [RW-1:0] in_rd = '0;
  logic          in_we = 1'b0;
  logic          in_flush = 1'b0;
  logic          out_valid;
  logic          in_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [FW-1:0] out_ALU_flag;
  logic [RW-1:0] out_rd;
  logic          out_we;
  logic          out_fwd_valid;
  logic [RW-1:0] out_fwd_rd;
  logic [DW-1:0] out_fwd_data;
  logic [1:0]    out_count;

  alu_result_stage #(.DATA_WIDTH(DW), .FLAG_WIDTH(FW), .RD_WIDTH(RW)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_valid(in_valid), .out_ready(out_ready),
    .in_data(in_data), .in_ALU_flag(in_ALU_flag), .in_rd(in_rd), .in_we(in_we),
    .in_flush(in_flush), .out_valid(out_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ALU_flag(out_ALU_flag), .out_rd(out_rd),
    .out_we(out_we), .out_fwd_valid(out_fwd_valid), .out_fwd_rd(out_fwd_rd),
    .out_fwd_data(out_fwd_data), .out_count(out_count)
  );

  always #5 in_clk = ~in_clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [FW-1:0] flag;
    logic [RW-1:0] rd;
    logic          we;
  } ref_entry_t;

  ref_entry_t ref_q [$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = ref_q.size();
    chk({tag, ".count"}, 64'(out_count), 64'(n));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(n > 0));
    chk({tag, ".out_ready"}, 64'(out_ready), 64'(n < 2));
    if (n > 0) begin
      chk({tag, ".out_data"}, out_data, ref_q[0].data);
      chk({tag, ".out_flag"}, 64'(out_ALU_flag), 64'(ref_q[0].flag));
      chk({tag, ".out_rd"}, 64'(out_rd), 64'(ref_q[0].rd));
      chk({tag, ".out_we"}, 64'(out_we), 64'(ref_q[0].we));
      chk({tag, ".fwd_valid"}, 64'(out_fwd_valid), 64'(ref_q[n-1].we));
      if (ref_q[n-1].we) begin
        chk({tag, ".fwd_rd"}, 64'(out_fwd_rd), 64'(ref_q[n-1].rd));
        chk({tag, ".fwd_data"}, out_fwd_data, ref_q[n-1].data);
      end
    end else begin
      chk({tag, ".empty_data"}, out_data, 64'd0);
      chk({tag, ".empty_flag"}, 64'(out_ALU_flag), 64'd0);
      chk({tag, ".empty_rd"}, 64'(out_rd), 64'd0);
      chk({tag, ".empty_we"}, 64'(out_we), 64'd0);
      chk({tag, ".empty_fwd"}, 64'(out_fwd_valid), 64'd0);
    end
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [RW-1:0] rd,
                       input logic we, input logic rdy, input logic fl);
    in_valid    = v;
    in_data     = d;
    in_ALU_flag = FW'(d[4:0] ^ 5'h15);
    in_rd       = rd;
    in_we       = we;
    in_ready    = rdy;
    in_flush    = fl;
  endtask

  // One clock: model the edge from the pre-edge inputs, then compare.
  task automatic step(input string tag);
    ref_entry_t e;
    bit acc, drn;
    @(posedge in_clk);
    acc = in_valid && (ref_q.size() < 2);
    drn = in_ready && (ref_q.size() > 0);
    if (in_flush) ref_q.delete();
    else begin
      if (drn) void'(ref_q.pop_front());
      if (acc) begin
        e.data = in_data;
        e.flag = in_ALU_flag;
        e.rd   = in_rd;
        e.we   = in_we && (in_rd != 0);
        ref_q.push_back(e);
      end
    end
    #1;
    check_all(tag);
    @(negedge in_clk);
  endtask

  initial begin
    #1;
    check_all("reset");
    @(negedge in_clk);
    in_rst = 1'b0;

    drive(1, 64'h1234, 5'd3, 1, 1, 0); step("single_acc");
    chk("single.data", out_data, 64'h1234);
    chk("single.rd", 64'(out_rd), 64'd3);
    drive(0, 0, 0, 0, 1, 0); step("single_drain");
    chk("single.count0", 64'(out_count), 64'd0);

    drive(1, 64'hA, 5'd1, 1, 0, 0); step("bp_a");
    drive(1, 64'hB, 5'd2, 1, 0, 0); step("bp_b");
    chk("bp.count2", 64'(out_count), 64'd2);
    chk("bp.ready0", 64'(out_ready), 64'd0);
    chk("bp.head_a", out_data, 64'hA);
    drive(1, 64'hC, 5'd4, 1, 0, 0); step("bp_hold");
    chk("bp.hold_a", out_data, 64'hA);
    drive(0, 0, 0, 0, 1, 0); step("bp_drain_a");
    chk("bp.head_b", out_data, 64'hB);
    step("bp_drain_b");

    drive(1, 64'h5, 5'd7, 1, 0, 0); step("sim_head5");
    drive(1, 64'h6, 5'd8, 1, 1, 0); step("sim_acc_drain");
    chk("sim.count1", 64'(out_count), 64'd1);
    chk("sim.data6", out_data, 64'h6);
    drive(0, 0, 0, 0, 1, 0); step("sim_empty");

    drive(1, 64'hFF, 5'd0, 1, 0, 0); step("x0");
    chk("x0.we", 64'(out_we), 64'd0);
    chk("x0.fwd", 64'(out_fwd_valid), 64'd0);
    chk("x0.data", out_data, 64'hFF);

    drive(1, 64'h77, 5'd9, 1, 0, 0); step("fl_fill");
    drive(1, 64'h99, 5'd10, 1, 1, 1); step("flush");
    chk("flush.count", 64'(out_count), 64'd0);
    chk("flush.valid", 64'(out_valid), 64'd0);
    drive(0, 0, 0, 0, 0, 0); step("flush_after");

    drive(1, 64'h11, 5'd1, 1, 0, 0); step("rst_fill1");
    drive(1, 64'h22, 5'd2, 1, 0, 0); step("rst_fill2");
    drive(0, 0, 0, 0, 0, 0);
    #2 in_rst = 1'b1;
    #1;
    ref_q.delete();
    chk("arst.valid", 64'(out_valid), 64'd0);
    chk("arst.count", 64'(out_count), 64'd0);
    check_all("arst");
    @(negedge in_clk);
    in_rst = 1'b0;
    drive(1, 64'h33, 5'd3, 1, 0, 0); step("arst_first");
    chk("arst.first", out_data, 64'h33);

    for (int i = 0; i < 500; i++) begin
      drive(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, RW'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, giving the ALU result width.
REQ-002 The block SHALL have parameter FLAG_WIDTH, default 5, giving the ALU flag width.
REQ-003 The block SHALL have parameter RD_WIDTH, default 5, giving the destination register address width.
REQ-004 The block SHALL have ports, one per line as name, direction, width, meaning:
- in_clk, input, 1: the single clock; all state changes on its rising edge.
- in_rst, input, 1: reset, asynchronous and active-high.
- in_valid, input, 1: upstream ALU result valid.
- out_ready, output, 1: stage can accept a result.
- in_data, input, DATA_WIDTH: ALU out_data.
- in_ALU_flag, input, FLAG_WIDTH: ALU out_ALU_flag.
- in_rd, input, RD_WIDTH: destination register.
- in_we, input, 1: register-write request.
- in_flush, input, 1: discard all held and incoming results.
- out_valid, output, 1: head entry valid.
- in_ready, input, 1: downstream accepts head.
- out_data, output, DATA_WIDTH: head result.
- out_ALU_flag, output, FLAG_WIDTH: head flags.
- out_rd, output, RD_WIDTH: head destination.
- out_we, output, 1: head write enable.
- out_fwd_valid, output, 1: forwarding entry valid.
- out_fwd_rd, output, RD_WIDTH: youngest held destination.
- out_fwd_data, output, DATA_WIDTH: youngest held result.
- out_count, output, 2: entries held (0..2).

Function
REQ-005 The stage SHALL be a 2-entry in-order buffer; an accept occurs when in_valid and out_ready are both 1 at a rising edge.
REQ-006 out_ready SHALL equal (count < 2) and SHALL depend only on registered state, never on in_ready.
REQ-007 A drain occurs when out_valid and in_ready are both 1 at a rising edge; out_valid SHALL equal (count > 0).
REQ-008 Latency from accept to out_valid SHALL be exactly 1 cycle; there SHALL be no combinational path from inputs to out_data, out_rd or out_we.
REQ-009 When count = 1, an accept and a drain in the same cycle SHALL leave count = 1, with the new entry as head the next cycle.
REQ-010 When count = 2, no accept SHALL occur; a drain SHALL promote the second entry to head and set count = 1.
REQ-011 Head outputs SHALL hold stable while out_valid = 1 and in_ready = 0.
REQ-012 An accepted entry with in_rd = 0 SHALL be stored with we = 0; data and flags are stored unchanged.
REQ-013 out_fwd_valid SHALL be 1 when the youngest held entry has we = 1; out_fwd_rd and out_fwd_data SHALL come from that entry. The youngest entry is entry 2 when count = 2 and the head when count = 1.
REQ-014 in_flush = 1 SHALL set count to 0 at the next edge, and SHALL take priority over any same-cycle accept or drain.
REQ-015 When count = 0, out_data, out_ALU_flag, out_rd and out_we SHALL read 0, and out_fwd_valid SHALL read 0.

Reset
REQ-016 Asserting in_rst SHALL immediately clear count and all entry fields to 0, making out_valid, out_we and out_fwd_valid 0 and out_ready 1.
REQ-017 Reset asserted mid-transfer SHALL discard every held entry; the first accept after release SHALL behave as from empty.

Structure
REQ-018 A shared package alu_pkg SHALL hold DATA_WIDTH, FLAG_WIDTH, RD_WIDTH and the result-entry struct (data, flag, rd, we) used by the ALU and this stage.
REQ-019 The block SHALL be a single flat module with no sub-module; storage is a 2-element entry array indexed by a 1-bit head pointer that wraps 1 to 0.

Verification
REQ-020 Single transfer: after reset, accept data=0x1234, rd=3, we=1 with in_ready=1 -> out_valid=1 one cycle later with out_data=0x1234, out_rd=3, then count=0.
REQ-021 Backpressure: in_ready=0, accept data A=0xA then B=0xB -> count=2 and out_ready=0; then in_ready=1 -> out_data=0xA and then 0xB, with no loss.
REQ-022 Simultaneous accept and drain at count=1 with in_ready=1: head 0x5, accept 0x6 -> count stays 1 and next out_data=0x6.
REQ-023 x0 suppression: accept rd=0, we=1, data=0xFF -> out_we=0, out_fwd_valid=0, out_data=0xFF.
REQ-024 Flush priority: count=2, in_flush=1 with in_valid=1 in the same cycle -> count=0 and out_valid=0 next cycle; the incoming entry is not stored.
REQ-025 Async reset: assert in_rst between clock edges at count=2 -> out_valid=0 and out_count=0 before the next edge.
